uart_tx_fifo: RTL

Parametrised successor to the single-byte UART `send` transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them onto `UART_TX` with a configurable word width, bit period, parity mode and stop-bit count. Frames are sent back-to-back with no idle gap while the FIFO holds data. It sits between the CPU's memory-mapped output path and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: valid/ready FIFO feeding a UART serialiser.
// Frames run back-to-back while words are queued. Word width, bit period,
// parity mode and stop-bit count are all set by parameters.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high, waiting for a queued word
// S_START | start bit (line low) for WAIT_TIME cycles
// S_DATA  | DATA_WIDTH data bits, LSB first
// S_PAR   | single parity bit (only when PARITY != 0)
// S_STOP  | STOP_BITS stop bits (line high); pops the next word on the last cycle
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_TIME  = 10,
  parameter int DEPTH      = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   valid,
  output logic                   ready,
  output logic                   UART_TX,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
  // DATA_WIDTH >= 5 gives at least 3 bits, which also covers the stop-bit index
  localparam int BW   = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0]   BAUD_LAST = CW'(WAIT_TIME - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;

  logic                  push, pop, baud_end;
  logic [DATA_WIDTH-1:0] head;

  assign ready    = (count_q != FULL);
  assign push     = valid && ready;
  assign baud_end = (baud_q == BAUD_LAST);
  // An empty FIFO can only be popped from S_STOP when a push lands in the
  // same cycle; the incoming word is forwarded straight to the serialiser.
  assign head     = (count_q == '0) ? data : mem_q[rd_ptr_q];

  assign UART_TX = tx_q;
  assign count   = count_q;
  assign busy    = (state_q != S_IDLE) || (count_q != '0);

  // FIFO storage: written on every accepted push, contents need no reset
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser next-state: line level is computed for the state being entered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~(^head) : (^head);
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if ((count_q != '0) || push) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (PARITY == 1) ? ~(^head) : (^head);
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serialiser registers; reset forces the line high and abandons any frame
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule
